// File: rtl/reg_dump_reader.sv
// reg_dump_reader: walks the register file x0..x31 two registers at a time
// and streams each word out over a valid/ready port.
//
// Optional feature: define REG_DUMP_CHECKSUM_EN to append a 64-bit XOR
// checksum word after x31. That word has index 0 and carries out_last.
//
// Stream handshake: a word transfers on a rising edge where out_valid and
// out_ready are both high. While out_valid=1 and out_ready=0, out_data,
// out_index and out_last hold steady. out_valid only drops after a transfer
// or on reset.
//
// dbg_state exposes the FSM state encoding for observation.
module reg_dump_reader (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic [4:0]  RS1,
   output logic [4:0]  RS2,
   input  logic [63:0] ReadData1,
   input  logic [63:0] ReadData2,
   output logic [63:0] out_data,
   output logic [4:0]  out_index,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_last,
   output logic        busy,
   output logic        done,
   output logic [2:0]  dbg_state
);

`ifdef REG_DUMP_CHECKSUM_EN
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FETCH   = 3'd1,
      SEND_A  = 3'd2,
      SEND_B  = 3'd3,
      SEND_CK = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FETCH   = 3'd1,
      SEND_A  = 3'd2,
      SEND_B  = 3'd3
   } state_t;
`endif

   state_t      state;
   logic [3:0]  p;        // pair counter: the current pair is x(2p), x(2p+1)
   logic [63:0] hold_b;   // odd word of the pair; out_data itself holds the even word
`ifdef REG_DUMP_CHECKSUM_EN
   logic [63:0] checksum;
`endif

   assign dbg_state = state;

   // Dump sequencer: every output is registered and updated on state transitions.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         p         <= 4'd0;
         hold_b    <= 64'd0;
         out_data  <= 64'd0;
         out_index <= 5'd0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         RS1       <= 5'd0;
         RS2       <= 5'd0;
`ifdef REG_DUMP_CHECKSUM_EN
         checksum  <= 64'd0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               // A start arriving during the done pulse is dropped on purpose.
               if (start && !done) begin
                  p     <= 4'd0;
                  busy  <= 1'b1;
                  RS1   <= 5'd0;
                  RS2   <= 5'd1;
                  state <= FETCH;
`ifdef REG_DUMP_CHECKSUM_EN
                  checksum <= 64'd0;
`endif
               end
            end

            FETCH: begin
               // Both words of the pair are sampled here and nowhere else.
               out_data  <= ReadData1;
               hold_b    <= ReadData2;
               out_index <= {p, 1'b0};
               out_last  <= 1'b0;
               out_valid <= 1'b1;
               RS1       <= 5'd0;
               RS2       <= 5'd0;
               state     <= SEND_A;
            end

            SEND_A: begin
               if (out_ready) begin
`ifdef REG_DUMP_CHECKSUM_EN
                  checksum <= checksum ^ out_data;
                  out_last <= 1'b0;
`else
                  out_last <= (p == 4'd15);
`endif
                  out_data  <= hold_b;
                  out_index <= {p, 1'b1};
                  state     <= SEND_B;
               end
            end

            SEND_B: begin
               if (out_ready) begin
                  if (p != 4'd15) begin
`ifdef REG_DUMP_CHECKSUM_EN
                     checksum <= checksum ^ out_data;
`endif
                     p         <= p + 4'd1;
                     RS1       <= {p + 4'd1, 1'b0};
                     RS2       <= {p + 4'd1, 1'b1};
                     out_valid <= 1'b0;
                     state     <= FETCH;
                  end else begin
`ifdef REG_DUMP_CHECKSUM_EN
                     // Fold x31 in while presenting the final checksum word.
                     checksum  <= checksum ^ out_data;
                     out_data  <= checksum ^ out_data;
                     out_index <= 5'd0;
                     out_last  <= 1'b1;
                     state     <= SEND_CK;
`else
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                     state     <= IDLE;
`endif
                  end
               end
            end

`ifdef REG_DUMP_CHECKSUM_EN
            SEND_CK: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  state     <= IDLE;
               end
            end
`endif

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Testbench for reg_dump_reader.
// The register file is a behavioural array read combinationally.
// Expected streams are built from a snapshot of that array.
module tb_reg_dump_reader;

   localparam int W = 70;   // {last, index[4:0], data[63:0]}
`ifdef REG_DUMP_CHECKSUM_EN
   localparam int N_WORDS  = 33;
   localparam int FULL_CYC = 49;
`else
   localparam int N_WORDS  = 32;
   localparam int FULL_CYC = 48;
`endif

   logic        clk;
   logic        reset;
   logic        start;
   logic [4:0]  RS1;
   logic [4:0]  RS2;
   logic [63:0] ReadData1;
   logic [63:0] ReadData2;
   logic [63:0] out_data;
   logic [4:0]  out_index;
   logic        out_valid;
   logic        out_ready;
   logic        out_last;
   logic        busy;
   logic        done;
   logic [2:0]  dbg_state;

   logic [63:0] rf [32];
   assign ReadData1 = rf[RS1];
   assign ReadData2 = rf[RS2];

   reg_dump_reader dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .RS1       (RS1),
      .RS2       (RS2),
      .ReadData1 (ReadData1),
      .ReadData2 (ReadData2),
      .out_data  (out_data),
      .out_index (out_index),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .busy      (busy),
      .done      (done),
      .dbg_state (dbg_state)
   );

   // Clock and reset defaults
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int errors = 0;
   int checks = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] obs_q[$];
   int done_count;
   int done_cyc;
   int stable_viol;
   logic last_busy;

   // Reference model: the dump is the register array in order, then the XOR of all words if enabled.
   function automatic void build_expected();
      logic [63:0] acc;
      logic [4:0] idx;
      acc = 64'd0;
      exp_q.delete();
      for (int k = 0; k < 32; k++) begin
         idx = k[4:0];
         exp_q.push_back({(k == 31) && (N_WORDS == 32), idx, rf[k]});
         acc = acc ^ rf[k];
      end
      if (N_WORDS == 33) exp_q.push_back({1'b1, 5'd0, acc});
   endfunction

   // Driver: one start pulse, accepted at the edge this task returns after.
   task automatic start_dump();
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Driver/monitor: cycles counted from the accept edge.
   // mode 0: ready held high; mode 1: ready toggles 1,0,...; mode 2: random ready.
   task automatic collect(input int mode, input int rs_a, input int rs_b,
                          input int stop_hs, input int budget);
      int cyc;
      int hs;
      logic pv;
      logic pr;
      logic [W-1:0] pw;
      cyc = 0; hs = 0; pv = 1'b0; pr = 1'b0; pw = '0;
      obs_q.delete();
      done_count = 0; done_cyc = -1; stable_viol = 0;
      while (cyc < budget) begin
         case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (cyc % 2 == 0);
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         start = (cyc == rs_a) || (cyc == rs_b);
         @(negedge clk);
         if (pv && !pr && (!out_valid || {out_last, out_index, out_data} != pw))
            stable_viol++;
         if (out_valid && out_ready) begin
            obs_q.push_back({out_last, out_index, out_data});
            hs++;
         end
         if (done) begin
            done_count++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         pv = out_valid;
         pr = out_ready;
         pw = {out_last, out_index, out_data};
         @(posedge clk); #1;
         cyc++;
         if (stop_hs > 0 && hs >= stop_hs) break;
      end
      start = 1'b0;
      last_busy = busy;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b1; out_ready = 1'b1;
      for (int k = 0; k < 32; k++) rf[k] = 64'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({out_valid, out_last, out_data, out_index, busy, done, RS1, RS2} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got valid=%b last=%b data=%h idx=%0d busy=%b done=%b rs1=%0d rs2=%0d, want all zero",
                  out_valid, out_last, out_data, out_index, busy, done, RS1, RS2);
      end
      checks++;
      if (dbg_state !== 3'd0) begin
         errors++;
         $display("FAIL reset_state: got %0d want 0", dbg_state);
      end
      @(posedge clk); #1;
      reset = 1'b0; start = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_dominates_start: busy=%b want 0", busy);
      end
   endtask

   task automatic test_full_throughput();
      for (int k = 0; k < 32; k++) rf[k] = 64'(k * 16);
      build_expected();
      start_dump();
      collect(0, -1, -1, 0, FULL_CYC + 6);
      checks++;
      if (obs_q.size() != N_WORDS) begin
         errors++;
         $display("FAIL full_count: got %0d words want %0d", obs_q.size(), N_WORDS);
      end else begin
         for (int i = 0; i < N_WORDS; i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
               errors++;
               $display("FAIL full_word%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
         end
      end
      checks++;
      if (done_cyc != FULL_CYC || done_count != 1) begin
         errors++;
         $display("FAIL full_done: done at %0d count %0d, want at %0d count 1", done_cyc, done_count, FULL_CYC);
      end
      checks++;
      if (last_busy !== 1'b0) begin
         errors++;
         $display("FAIL full_busy_end: busy=%b want 0", last_busy);
      end
   endtask

   task automatic test_backpressure();
      for (int k = 0; k < 32; k++) rf[k] = 64'(k * 16);
      build_expected();
      start_dump();
      collect(1, -1, -1, 0, 150);
      checks++;
      if (obs_q.size() != N_WORDS) begin
         errors++;
         $display("FAIL bp_count: got %0d words want %0d", obs_q.size(), N_WORDS);
      end else begin
         for (int i = 0; i < N_WORDS; i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
               errors++;
               $display("FAIL bp_word%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
         end
      end
      checks++;
      if (stable_viol != 0) begin
         errors++;
         $display("FAIL bp_stable: %0d unstable stall cycles, want 0", stable_viol);
      end
      checks++;
      if (done_count != 1) begin
         errors++;
         $display("FAIL bp_done: count %0d want 1", done_count);
      end
   endtask

   task automatic test_extra_starts();
      for (int k = 0; k < 32; k++) rf[k] = 64'd0;
      rf[21] = 64'd1;
      build_expected();
      start_dump();
      collect(0, 5, 20, 0, FULL_CYC + 10);
      checks++;
      if (obs_q.size() != N_WORDS || done_count != 1) begin
         errors++;
         $display("FAIL extra_starts: got %0d words %0d done, want %0d words 1 done",
                  obs_q.size(), done_count, N_WORDS);
      end else begin
         for (int i = 0; i < N_WORDS; i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
               errors++;
               $display("FAIL x21_word%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
         end
`ifdef REG_DUMP_CHECKSUM_EN
         checks++;
         if (obs_q[32][63:0] !== 64'h1) begin
            errors++;
            $display("FAIL x21_checksum: got %h want 1", obs_q[32][63:0]);
         end
`endif
      end
   endtask

   task automatic test_done_start();
      for (int k = 0; k < 32; k++) rf[k] = 64'($urandom);
      start_dump();
      collect(0, FULL_CYC, -1, 0, FULL_CYC + 6);
      checks++;
      if (last_busy !== 1'b0 || done_count != 1 || obs_q.size() != N_WORDS) begin
         errors++;
         $display("FAIL start_with_done: busy=%b done=%0d words=%0d, want busy=0 done=1 words=%0d",
                  last_busy, done_count, obs_q.size(), N_WORDS);
      end
      start_dump();
      collect(0, FULL_CYC + 1, -1, 0, FULL_CYC + 6);
      checks++;
      if (last_busy !== 1'b1 || obs_q.size() <= N_WORDS) begin
         errors++;
         $display("FAIL start_after_done: busy=%b words=%0d, want busy=1 words>%0d",
                  last_busy, obs_q.size(), N_WORDS);
      end
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic test_reset_mid();
      for (int k = 0; k < 32; k++) rf[k] = 64'(k * 16);
      start_dump();
      collect(0, -1, -1, 10, 100);
      reset = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if ({out_valid, out_last, out_data, out_index, busy, done, RS1, RS2} !== '0) begin
         errors++;
         $display("FAIL midreset_outputs: valid=%b last=%b data=%h idx=%0d busy=%b done=%b, want all zero",
                  out_valid, out_last, out_data, out_index, busy, done);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      collect(0, -1, -1, 0, 8);
      checks++;
      if (done_count != 0 || obs_q.size() != 0) begin
         errors++;
         $display("FAIL midreset_abort: done=%0d words=%0d want 0 and 0", done_count, obs_q.size());
      end
      for (int k = 0; k < 32; k++) rf[k] = {$urandom, $urandom};
      build_expected();
      start_dump();
      collect(0, -1, -1, 0, FULL_CYC + 4);
      checks++;
      if (obs_q.size() != N_WORDS) begin
         errors++;
         $display("FAIL midreset_restart_count: got %0d want %0d", obs_q.size(), N_WORDS);
      end else begin
         for (int i = 0; i < N_WORDS; i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
               errors++;
               $display("FAIL restart_word%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
         end
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 3; it++) begin
         for (int k = 0; k < 32; k++) rf[k] = {$urandom, $urandom};
         build_expected();
         start_dump();
         collect(2, -1, -1, 0, 400);
         checks++;
         if (obs_q.size() != N_WORDS || done_count != 1 || stable_viol != 0) begin
            errors++;
            $display("FAIL rand%0d_shape: words=%0d done=%0d unstable=%0d, want %0d 1 0",
                     it, obs_q.size(), done_count, stable_viol, N_WORDS);
         end else begin
            for (int i = 0; i < N_WORDS; i++) begin
               checks++;
               if (obs_q[i] !== exp_q[i]) begin
                  errors++;
                  $display("FAIL rand%0d_word%0d: got %h want %h", it, i, obs_q[i], exp_q[i]);
               end
            end
         end
      end
   endtask

`ifdef REG_DUMP_CHECKSUM_EN
   task automatic test_checksum();
      for (int k = 0; k < 32; k++) rf[k] = 64'(k);
      start_dump();
      collect(0, -1, -1, 0, FULL_CYC + 4);
      checks++;
      if (obs_q.size() != 33) begin
         errors++;
         $display("FAIL ck_count: got %0d want 33", obs_q.size());
      end else begin
         checks++;
         if (obs_q[32] !== {1'b1, 5'd0, 64'd0}) begin
            errors++;
            $display("FAIL ck_word: got %h want last=1 idx=0 data=0", obs_q[32]);
         end
      end
      checks++;
      if (done_cyc != 49) begin
         errors++;
         $display("FAIL ck_done_cycle: got %0d want 49", done_cyc);
      end
   endtask
`endif

   // Test sequence and final report
   initial begin
      reset = 1'b1; start = 1'b0; out_ready = 1'b0;
      test_reset();
      test_full_throughput();
      test_backpressure();
      test_extra_starts();
      test_done_start();
      test_reset_mid();
      test_random();
`ifdef REG_DUMP_CHECKSUM_EN
      test_checksum();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/reg_dump_reader.md
REG_DUMP_READER -- requirements
Module: reg_dump_reader

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port start, input, 1, one-cycle request to begin a full dump of x0..x31.
REQ-004 SHALL have ports RS1 and RS2, output, 5 each, read addresses driven to the register file's two read ports.
REQ-005 SHALL have ports ReadData1 and ReadData2, input, 64 each, register file read data, valid combinationally in the same cycle as RS1/RS2.
REQ-006 SHALL have ports out_data (output, 64), out_index (output, 5), out_valid (output, 1) and out_ready (input, 1), a valid/ready stream of dumped words.
REQ-007 SHALL have port out_last, output, 1, high with the final word of a dump.
REQ-008 SHALL have ports busy and done, output, 1 each; busy covers start accept through final handshake; done is a one-cycle pulse after the final handshake.

Function
REQ-009 SHALL implement states IDLE, FETCH, SEND_A, SEND_B and, when configured, SEND_CK.
REQ-010 IDLE: RS1=RS2=0, out_valid=0, busy=0; start=1 SHALL clear the 4-bit pair counter p and go to FETCH next cycle.
REQ-011 FETCH (exactly 1 cycle): RS1=2p, RS2=2p+1; SHALL latch ReadData1 into hold_a and ReadData2 into hold_b at the edge, then go to SEND_A.
REQ-012 SEND_A: out_valid=1, out_data=hold_a, out_index=2p; on out_valid&out_ready SHALL go to SEND_B.
REQ-013 SEND_B: out_valid=1, out_data=hold_b, out_index=2p+1; on handshake, if p<15 SHALL increment p and go to FETCH, else go to end-of-dump (REQ-016/REQ-021).
REQ-014 out_data, out_index and out_last SHALL stay stable while out_valid=1 and out_ready=0; out_valid SHALL never drop without a handshake except on reset.
REQ-015 Handshake throughput: one word per cycle within a pair; FETCH adds one bubble per pair, so a 32-word dump with out_ready held high takes 48 cycles from start accept to done.
REQ-016 End of dump (checksum not compiled in): out_last=1 in SEND_B with p=15; after that handshake, done=1 for one cycle and state returns to IDLE.
REQ-017 start while busy=1 SHALL be ignored; start coincident with done SHALL be ignored; start in the cycle after done SHALL be accepted.
REQ-018 p SHALL not wrap during a dump; wrap 15->0 occurs only through a new start.
REQ-019 Register contents changing between dumps SHALL be reflected; a word is sampled only in its FETCH cycle.

Reset
REQ-020 reset=1 at a rising edge SHALL force IDLE, p=0, hold_a=hold_b=0, checksum=0, out_valid=0, out_last=0, out_data=0, out_index=0, busy=0, done=0, RS1=RS2=0; reset mid-dump SHALL abort it with no done pulse; reset SHALL dominate start in the same cycle.

Configuration
REQ-021 With macro REG_DUMP_CHECKSUM_EN defined: a 64-bit XOR accumulator SHALL clear on start accept and absorb each data word on its handshake; after the SEND_B p=15 handshake go to SEND_CK presenting out_data=checksum, out_index=0, out_last=1 (out_last=0 in SEND_B); done follows the SEND_CK handshake (49 cycles at full throughput); without the macro SEND_CK and the accumulator SHALL not exist and REQ-016 applies.

Verification
REQ-022 Preload xk=k*0x10 for all k, start pulse, out_ready=1 -> 32 words 0x000..0x1F0 with out_index 0..31, out_last on index 31, done at cycle 48.
REQ-023 Same preload, out_ready toggled 1,0,1,0 -> identical sequence, data/index stable during every ready=0 cycle, no duplicated or dropped word.
REQ-024 Preload x21=1 else 0, start re-pulsed at cycles 5 and 20 -> single dump, only word 21 nonzero, extra starts ignored.
REQ-025 Assert reset after the 10th handshake, then start again -> outputs zero during reset, no done, new dump begins from index 0.
REQ-026 REG_DUMP_CHECKSUM_EN defined, preload xk=k -> 33rd word 0x0000000000000000 (XOR of 0..31) with out_last=1; with x21=1 only -> checksum 0x1.
